ctl_reg_arbiter: RTL and testbench

Shares the single-port controller register RAM between two requesters: CPU bus writes on the controller window and an internal FPGA requester (status/sequencer logic) doing reads and writes. CPU writes are edge-detected on the bus clock and queued in a 2-entry FIFO. Access is round-robin when both requesters are pending. Sits between the CPU bus controller port and the register RAM instance.

---
 rtl/ctl_reg_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ctl_reg_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_reg_arbiter.sv
// rtl/ctl_reg_arbiter.sv - Arbitrates the controller register RAM between queued CPU writes and an internal requester.
// CPU commits are edge-detected into a 2-entry FIFO; ties between CPU and internal requests alternate round-robin.
module ctl_reg_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  BUS_CLK,
  input  logic                  RST_N,
  input  logic                  CTL_EN,
  input  logic                  WE,
  input  logic [13:0]           BRAM_ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  INT_REQ,
  input  logic                  INT_WE,
  input  logic [ADDR_WIDTH-1:0] INT_ADDR,
  input  logic [DATA_WIDTH-1:0] INT_WDATA,
  output logic                  INT_ACK,
  output logic [DATA_WIDTH-1:0] INT_RDATA,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT,
  output logic                  CPU_OVF
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CPU_WR,
    INT_WR,
    INT_RD,
    INT_RD_WAIT
  } state_t;

  state_t          state;
  logic [2:0]      we_edge;
  logic [EW-1:0]   fifo_mem [2];
  logic            fifo_rd_ptr;
  logic            fifo_wr_ptr;
  logic [1:0]      fifo_cnt;
  logic            last_grant_cpu;

  logic            commit;
  logic            fifo_full;
  logic            fifo_pop;
  logic            fifo_push;
  logic            cpu_pend;
  logic            int_pend;
  logic            grant_cpu;
  logic            grant_int;
  logic [EW-1:0]   fifo_head;

  // Only the low ADDR_WIDTH bits of the CPU word address reach the RAM.
  generate
    if (ADDR_WIDTH < 14) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^BRAM_ADDR[13:ADDR_WIDTH];
    end
  endgenerate

  assign commit    = (we_edge == 3'b011);
  assign fifo_full = (fifo_cnt == 2'd2);
  assign fifo_pop  = (state == CPU_WR) && (fifo_cnt != 2'd0);
  assign fifo_push = commit && (!fifo_full || fifo_pop);
  assign fifo_head = fifo_mem[fifo_rd_ptr];

  // The requester's own ACK cycle must not re-grant the request it just completed.
  assign cpu_pend  = (fifo_cnt != 2'd0);
  assign int_pend  = INT_REQ && !INT_ACK;
  assign grant_cpu = (state == IDLE) && cpu_pend && (!int_pend || !last_grant_cpu);
  assign grant_int = (state == IDLE) && int_pend && !grant_cpu;

  always_ff @(posedge BUS_CLK) begin
    if (fifo_push) begin
      fifo_mem[fifo_wr_ptr] <= {BRAM_ADDR[ADDR_WIDTH-1:0], DATA_IN};
    end
  end

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_edge     <= 3'b000;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
      CPU_OVF     <= 1'b0;
    end else begin
      we_edge  <= {we_edge[1:0], WE & CTL_EN};
      fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
      if (fifo_push) begin
        fifo_wr_ptr <= ~fifo_wr_ptr;
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      if (commit && !fifo_push) begin
        CPU_OVF <= 1'b1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      last_grant_cpu <= 1'b0;
      RAM_EN         <= 1'b0;
      RAM_WE         <= 1'b0;
      RAM_ADDR       <= '0;
      RAM_DIN        <= '0;
      INT_ACK        <= 1'b0;
      INT_RDATA      <= '0;
    end else begin
      RAM_EN  <= 1'b0;
      RAM_WE  <= 1'b0;
      INT_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state          <= CPU_WR;
            last_grant_cpu <= 1'b1;
            RAM_EN         <= 1'b1;
            RAM_WE         <= 1'b1;
            RAM_ADDR       <= fifo_head[EW-1:DATA_WIDTH];
            RAM_DIN        <= fifo_head[DATA_WIDTH-1:0];
          end else if (grant_int) begin
            last_grant_cpu <= 1'b0;
            RAM_EN         <= 1'b1;
            RAM_WE         <= INT_WE;
            RAM_ADDR       <= INT_ADDR;
            if (INT_WE) begin
              RAM_DIN <= INT_WDATA;
              state   <= INT_WR;
            end else begin
              state   <= INT_RD;
            end
          end
        end
        CPU_WR: begin
          state <= IDLE;
        end
        INT_WR: begin
          INT_ACK <= 1'b1;
          state   <= IDLE;
        end
        INT_RD: begin
          state <= INT_RD_WAIT;
        end
        INT_RD_WAIT: begin
          INT_RDATA <= RAM_DOUT;
          INT_ACK   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_reg_arbiter.sv
// tb/tb_ctl_reg_arbiter.sv - Self-checking bench for ctl_reg_arbiter.
// A transaction-level model predicts every output cycle; directed scenarios pin the model with literals.
module tb_ctl_reg_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          BUS_CLK   = 1'b0;
  logic          RST_N     = 1'b1;
  logic          CTL_EN    = 1'b0;
  logic          WE        = 1'b0;
  logic [13:0]   BRAM_ADDR = '0;
  logic [DW-1:0] DATA_IN   = '0;
  logic          INT_REQ   = 1'b0;
  logic          INT_WE    = 1'b0;
  logic [AW-1:0] INT_ADDR  = '0;
  logic [DW-1:0] INT_WDATA = '0;
  logic          INT_ACK;
  logic [DW-1:0] INT_RDATA;
  logic          RAM_EN;
  logic          RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DIN;
  logic [DW-1:0] RAM_DOUT  = '0;
  logic          CPU_OVF;

  ctl_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .BUS_CLK   (BUS_CLK),
    .RST_N     (RST_N),
    .CTL_EN    (CTL_EN),
    .WE        (WE),
    .BRAM_ADDR (BRAM_ADDR),
    .DATA_IN   (DATA_IN),
    .INT_REQ   (INT_REQ),
    .INT_WE    (INT_WE),
    .INT_ADDR  (INT_ADDR),
    .INT_WDATA (INT_WDATA),
    .INT_ACK   (INT_ACK),
    .INT_RDATA (INT_RDATA),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_DIN   (RAM_DIN),
    .RAM_DOUT  (RAM_DOUT),
    .CPU_OVF   (CPU_OVF)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Register RAM instance: synchronous write, 1-cycle read latency.
  logic [DW-1:0] ram_mem [256];
  always @(posedge BUS_CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) ram_mem[RAM_ADDR] <= RAM_DIN;
      else        RAM_DOUT <= ram_mem[RAM_ADDR];
    end
  end

  // Reference model: contents of RAM, CPU queue, and which cycles carry an access or an ACK.
  typedef struct packed {logic [7:0] a; logic [15:0] d;} ent_t;
  ent_t          mq[$];
  logic [DW-1:0] ref_mem [256];
  int            cyc = 0;
  int            run = 0;
  int            next_free = 0;
  int            acc_cyc = -1;
  int            ack_cyc = -1;
  bit            acc_we, acc_cpu, ack_rd, last_cpu, m_ovf;
  logic [7:0]    acc_addr;
  logic [15:0]   acc_din, ack_data;
  bit            e_en, e_we, e_ack, e_ovf;
  logic [7:0]    e_addr;
  logic [15:0]   e_din, e_rdata;

  always @(negedge BUS_CLK) begin
    if (!RST_N) begin
      mq.delete();
      run = 0; next_free = 0; acc_cyc = -1; ack_cyc = -1;
      last_cpu = 0; m_ovf = 0;
      e_en = 0; e_we = 0; e_addr = 0; e_din = 0; e_ack = 0; e_rdata = 0; e_ovf = 0;
      chk($sformatf("reset_outputs@%0d", cyc),
          {RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN, INT_ACK, INT_RDATA, CPU_OVF}, 64'd0);
    end else begin
      bit commit, pop, cpu_p, int_p;
      chk($sformatf("cycle@%0d {en,we,addr,din,ack,rdata,ovf}", cyc),
          {RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN, INT_ACK, INT_RDATA, CPU_OVF},
          {e_en, e_we, e_addr, e_din, e_ack, e_rdata, e_ovf});
      // A commit is the second consecutive sampled cycle of WE&CTL_EN after a low sample.
      commit = (run == 2);
      run = (WE && CTL_EN) ? ((run < 3) ? run + 1 : 3) : 0;
      pop = acc_cpu && (acc_cyc == cyc);
      if (cyc >= next_free) begin
        cpu_p = (mq.size() > 0);
        int_p = INT_REQ && (ack_cyc != cyc);
        if (cpu_p && (!int_p || !last_cpu)) begin
          acc_cyc = cyc + 1; acc_cpu = 1; acc_we = 1;
          acc_addr = mq[0].a; acc_din = mq[0].d;
          ref_mem[acc_addr] = acc_din;
          next_free = cyc + 2; last_cpu = 1;
        end else if (int_p) begin
          acc_cyc = cyc + 1; acc_cpu = 0; acc_we = INT_WE; acc_addr = INT_ADDR;
          last_cpu = 0;
          if (INT_WE) begin
            acc_din = INT_WDATA; ref_mem[acc_addr] = acc_din;
            ack_cyc = cyc + 2; ack_rd = 0; next_free = cyc + 2;
          end else begin
            ack_data = ref_mem[acc_addr];
            ack_cyc = cyc + 3; ack_rd = 1; next_free = cyc + 3;
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (commit) begin
        if (mq.size() < 2) mq.push_back('{a: BRAM_ADDR[7:0], d: DATA_IN});
        else m_ovf = 1;
      end
      e_en = (acc_cyc == cyc + 1);
      e_we = e_en && acc_we;
      if (e_en) e_addr = acc_addr;
      if (e_en && acc_we) e_din = acc_din;
      e_ack = (ack_cyc == cyc + 1);
      if (e_ack && ack_rd) e_rdata = ack_data;
      e_ovf = m_ovf;
    end
    cyc++;
  end

  // Activity counters and write-order log used by the directed scenarios.
  int         wr_cnt = 0, en_cnt = 0, ack_cnt = 0;
  logic [7:0] last_wr_addr = '0;
  logic [7:0] wr_log[$];
  bit         int_outstanding = 0;

  always @(negedge BUS_CLK) begin
    if (RST_N) begin
      if (RAM_EN) en_cnt++;
      if (RAM_EN && RAM_WE) begin
        wr_cnt++; last_wr_addr = RAM_ADDR; wr_log.push_back(RAM_ADDR);
      end
      if (INT_ACK) ack_cnt++;
    end
    if (RST_N && int_outstanding && !INT_REQ && !INT_ACK)
      $error("protocol: INT_REQ dropped before INT_ACK");
    int_outstanding = RST_N && !INT_ACK && INT_REQ;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge BUS_CLK);
      #1;
    end
  endtask

  task automatic cpu_commit(input logic en, input logic [13:0] a, input logic [15:0] d,
                            input int hi, input int lo);
    CTL_EN = en; WE = 1'b1; BRAM_ADDR = a; DATA_IN = d;
    tick(hi);
    WE = 1'b0;
    tick(lo);
  endtask

  task automatic int_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                            output logic [15:0] rd);
    int n = 0;
    INT_REQ = 1'b1; INT_WE = we; INT_ADDR = a; INT_WDATA = d;
    do begin
      tick(1);
      n++;
    end while (!INT_ACK && n < 60);
    chk("int_ack_wait", {63'd0, INT_ACK}, 64'd1);
    rd = INT_RDATA;
  endtask

  logic [15:0] rd;
  bit          stop_int;
  int          snap_wr, snap_en, snap_ack;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    ram_mem[5] = 16'h1234;
    ref_mem[5] = 16'h1234;
    #1 RST_N = 1'b0;
    tick(3);
    chk("rst_ram_en", {63'd0, RAM_EN}, 64'd0);
    chk("rst_int_ack", {63'd0, INT_ACK}, 64'd0);
    chk("rst_cpu_ovf", {63'd0, CPU_OVF}, 64'd0);
    RST_N = 1'b1;
    tick(2);

    // Single CPU write.
    snap_wr = wr_cnt;
    cpu_commit(1'b1, 14'h0012, 16'hBEEF, 3, 1);
    tick(6);
    chk("cpu_wr_count", 64'(wr_cnt - snap_wr), 64'd1);
    chk("cpu_wr_addr", {56'd0, last_wr_addr}, 64'h12);
    chk("cpu_wr_mem", {48'd0, ram_mem[8'h12]}, 64'hBEEF);
    chk("cpu_wr_ovf", {63'd0, CPU_OVF}, 64'd0);

    // Internal read of a preloaded word.
    snap_en = en_cnt; snap_ack = ack_cnt;
    int_access(1'b0, 8'h05, 16'h0, rd);
    INT_REQ = 1'b0;
    chk("int_rd_data", {48'd0, rd}, 64'h1234);
    tick(5);
    chk("int_rd_accesses", 64'(en_cnt - snap_en), 64'd1);
    chk("int_rd_acks", 64'(ack_cnt - snap_ack), 64'd1);

    // Contention: CPU writes queued behind an internal read, internal write follows.
    wr_log.delete();
    fork
      begin
        int_access(1'b0, 8'h40, 16'h0, rd);
        int_access(1'b1, 8'h03, 16'hCCCC, rd);
        INT_REQ = 1'b0;
      end
      begin
        cpu_commit(1'b1, 14'h0001, 16'hAAAA, 2, 2);
        cpu_commit(1'b1, 14'h0002, 16'hBBBB, 2, 1);
      end
    join
    tick(10);
    chk("order_len", 64'(wr_log.size()), 64'd3);
    chk("order_0", {56'd0, (wr_log.size() > 0) ? wr_log[0] : 8'hFF}, 64'h01);
    chk("order_1", {56'd0, (wr_log.size() > 1) ? wr_log[1] : 8'hFF}, 64'h03);
    chk("order_2", {56'd0, (wr_log.size() > 2) ? wr_log[2] : 8'hFF}, 64'h02);
    chk("order_mem", {48'd0, ram_mem[8'h03]}, 64'hCCCC);

    // Overflow: 3 commits keep up, a longer burst against back-to-back reads must drop.
    for (int burst = 0; burst < 2; burst++) begin
      stop_int = 0;
      fork
        begin
          while (!stop_int) int_access(1'b0, 8'($urandom_range(0, 255)), 16'h0, rd);
          INT_REQ = 1'b0;
        end
        begin
          repeat (burst == 0 ? 3 : 10)
            cpu_commit(1'b1, 14'($urandom), 16'($urandom), 2, 1);
          tick(20);
          stop_int = 1;
        end
      join
      tick(10);
      chk(burst == 0 ? "ovf_after_3" : "ovf_after_burst", {63'd0, CPU_OVF},
          burst == 0 ? 64'd0 : 64'd1);
    end
    tick(30);
    chk("ovf_sticky", {63'd0, CPU_OVF}, 64'd1);
    RST_N = 1'b0;
    tick(1);
    chk("ovf_cleared_by_reset", {63'd0, CPU_OVF}, 64'd0);
    RST_N = 1'b1;
    tick(2);

    // WE held long commits once; WE without CTL_EN never commits.
    snap_wr = wr_cnt;
    CTL_EN = 1'b1; WE = 1'b1; BRAM_ADDR = 14'h0077; DATA_IN = 16'h7777;
    tick(20);
    WE = 1'b0;
    tick(6);
    chk("we_held_single", 64'(wr_cnt - snap_wr), 64'd1);
    snap_wr = wr_cnt;
    CTL_EN = 1'b0; WE = 1'b1;
    tick(8);
    WE = 1'b0;
    tick(6);
    chk("ctl_en_low_none", 64'(wr_cnt - snap_wr), 64'd0);

    // Reset while the read result is in flight.
    int_access(1'b0, 8'h05, 16'h0, rd);
    INT_REQ = 1'b0;
    tick(3);
    INT_REQ = 1'b1; INT_WE = 1'b0; INT_ADDR = 8'h22;
    tick(1);
    chk("rd_before_reset_en", {63'd0, RAM_EN}, 64'd1);
    tick(1);
    RST_N = 1'b0;
    #1;
    chk("reset_async_outputs", {RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN, INT_ACK, INT_RDATA, CPU_OVF}, 64'd0);
    INT_REQ = 1'b0;
    tick(2);
    RST_N = 1'b1;
    snap_ack = ack_cnt; snap_en = en_cnt;
    tick(8);
    chk("no_ack_after_reset", 64'(ack_cnt - snap_ack), 64'd0);
    chk("no_access_after_reset", 64'(en_cnt - snap_en), 64'd0);

    // Randomized traffic from both requesters.
    fork
      begin
        repeat (150)
          cpu_commit(logic'($urandom_range(0, 9) != 0),
                     {6'($urandom), 8'($urandom_range(0, 31))}, 16'($urandom),
                     $urandom_range(1, 5), $urandom_range(1, 4));
      end
      begin
        repeat (120) begin
          int gap;
          int_access(logic'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 16'($urandom), rd);
          gap = $urandom_range(0, 4);
          if (gap > 0) begin
            INT_REQ = 1'b0;
            tick(gap);
          end
        end
        INT_REQ = 1'b0;
      end
    join
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
